// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and
// frame defaults common to the TX and RX sides.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_PRESCALE   = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the receiver: oversampling counter, 3-point majority
// vote around mid-bit and the end-of-bit decision pulse.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = UART_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic rxs_i,
  output logic bit_end_o,
  output logic sample_o
);

  localparam int CW  = $clog2(PRESCALE);
  localparam int MID = PRESCALE / 2;
  // With PRESCALE=4 the last vote point coincides with the decision cycle.
  localparam bit LATE_LIVE = (MID + 1 == PRESCALE - 1);

  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]    vote_q;
  logic          late;

  assign bit_end_o = en_i && (edge_cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    edge_cnt_d = '0;
    if (en_i && !bit_end_o) edge_cnt_d = edge_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      vote_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (en_i) begin
        if (edge_cnt_q == CW'(MID - 1)) vote_q[0] <= rxs_i;
        if (edge_cnt_q == CW'(MID))     vote_q[1] <= rxs_i;
        if (edge_cnt_q == CW'(MID + 1)) vote_q[2] <= rxs_i;
      end
    end
  end

  assign late     = LATE_LIVE ? rxs_i : vote_q[2];
  assign sample_o = maj3(vote_q[0], vote_q[1], late);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, frames start/data/parity/stop bits and
// emits one-cycle valid or error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESCALE   = UART_PRESCALE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  Data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]            sync_q, sync_d;
  logic                  rxs;
  rx_state_e             state_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_en_q, par_typ_q, par_bad_q;
  logic                  dv_q, pe_q, se_q, busy_q;
  logic                  bit_end, sample;

  assign sync_d = {sync_q[0], RX_IN};
  assign rxs    = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != IDLE),
    .rxs_i     (rxs),
    .bit_end_o (bit_end),
    .sample_o  (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q   <= START;
            busy_q    <= 1'b1;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad_q <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            if (sample) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q[bit_cnt_q] <= sample;
            if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_q <= par_en_q ? PARITY : STOP;
            else bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          // Even parity expects XOR(data)==bit, odd the inverse.
          if (bit_end) begin
            par_bad_q <= (^shift_q) ^ sample ^ par_typ_q;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            se_q    <= !sample;
            pe_q    <= par_bad_q;
            if (sample && !par_bad_q) begin
              dv_q     <= 1'b1;
              p_data_q <= shift_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P_data     = p_data_q;
  assign Data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame stimulus for uart_rx, checked against a frame-level
// timing/outcome model and an event scoreboard.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW = UART_DATA_WIDTH;
  localparam int PS = UART_PRESCALE;

  logic          clk = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          dv, pe, se, busy;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .RX_IN(rx_in), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_data(p_data), .Data_valid(dv), .par_err(pe), .stp_err(se), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic dv, pe, se; logic [DW-1:0] d; } ev_t;
  ev_t got_q[$], exp_q[$];

  int            n_vec = 0, n_err = 0;
  logic [DW-1:0] last_good = '0;
  int            last_idle = 0, last_slip = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv || pe || se) begin
      got_q.push_back('{cyc, dv, pe, se, p_data});
      chk("busy_at_strobe", busy, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // gbit: frame bit to carry a 1-cycle mid-bit glitch; rbit: frame bit in which reset pulses.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic pflip, input logic stopb, input int gbit, input int rbit);
    int             nb, e0, entry;
    logic [DW+2:0]  fr;
    logic           perr, serr, dvx;
    nb = DW + 2 + int'(pen);
    fr = '0;
    for (int i = 0; i < DW; i++) fr[i+1] = d[i];
    if (pen) begin
      fr[DW+1] = (^d) ^ ptyp ^ pflip;
      fr[DW+2] = stopb;
    end else begin
      fr[DW+1] = stopb;
    end
    e0 = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < PS; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) begin
          e0 = cyc + 1;
          par_en = pen;
          par_typ = ptyp;
        end
        if (b == 3 && c == 0) begin
          par_en = 1'($urandom);
          par_typ = 1'($urandom);
        end
        if (b == rbit && c == PS / 2) begin
          rst = 1'b1;
          rx_in = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("rst_pdata", p_data, 0);
          chk("rst_dv", dv, 0);
          chk("rst_perr", pe, 0);
          chk("rst_serr", se, 0);
          chk("rst_busy", busy, 0);
          last_good = '0;
          last_idle = cyc;
          last_slip = 0;
          return;
        end
        rx_in = fr[b] ^ ((b == gbit) && (c == PS / 2));
        if (b == nb - 1 && c == PS - 1) chk("busy_in_frame", busy, 1);
      end
    end
    // FSM can only accept a start one cycle after it re-entered IDLE.
    entry = (e0 + 2 > last_idle + 1) ? e0 + 2 : last_idle + 1;
    last_slip = entry - (e0 + 2);
    last_idle = entry + nb * PS;
    perr = pen & pflip;
    serr = !stopb;
    dvx  = !perr && !serr;
    if (dvx) last_good = d;
    exp_q.push_back('{last_idle, dvx, perr, serr, last_good});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, g;
    repeat (2) @(negedge clk);
    chk("reset_pdata", p_data, 0);
    chk("reset_dv", dv, 0);
    chk("reset_perr", pe, 0);
    chk("reset_serr", se, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);      idle(12);
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, -1);  idle(12);
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, -1);  idle(12);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);      idle(12);

    // Two-cycle low pulse: START must reject it without a strobe.
    @(negedge clk); rx_in = 1'b0; e0 = cyc + 1;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b1;
    wait_cyc(e0 + 4);
    chk("glitch_busy_hi", busy, 1);
    wait_cyc(e0 + 1 + PS);
    chk("glitch_busy_end", busy, 1);
    wait_cyc(e0 + 2 + PS);
    chk("glitch_busy_lo", busy, 0);
    last_idle = e0 + 2 + PS;
    idle(12);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1);
    idle(12);

    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5);
    idle(12);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(12);

    for (int k = 0; k < 40; k++) begin
      g = $urandom_range(0, 10);
      if (g == 0 && last_slip != 0) g = 1;
      idle(g);
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW) : -1, -1);
    end
    idle(100);

    chk("event_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("ev%0d_cyc", i), got_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("ev%0d_dv", i), got_q[i].dv, exp_q[i].dv);
      chk($sformatf("ev%0d_perr", i), got_q[i].pe, exp_q[i].pe);
      chk($sformatf("ev%0d_serr", i), got_q[i].se, exp_q[i].se);
      chk($sformatf("ev%0d_pdata", i), got_q[i].d, exp_q[i].d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
